// File: rtl/h_data_port_arbiter_if.sv
// rtl/h_data_port_arbiter_if.sv - requester, BRAM port A and read-return bundle for the H-data arbiter
interface h_data_port_arbiter_if #(
    parameter int H_DATA_ADDR_W = 18,
    parameter int H_DATA_WIDTH  = 19
);
    logic                     req0_vld;
    logic                     req0_last;
    logic                     req0_we;
    logic [H_DATA_ADDR_W-1:0] req0_addr;
    logic [H_DATA_WIDTH-1:0]  req0_din;
    logic                     req0_rdy;

    logic                     req1_vld;
    logic                     req1_last;
    logic                     req1_we;
    logic [H_DATA_ADDR_W-1:0] req1_addr;
    logic [H_DATA_WIDTH-1:0]  req1_din;
    logic                     req1_rdy;

    logic [H_DATA_ADDR_W-1:0] h_data_bram_addra;
    logic [H_DATA_WIDTH-1:0]  h_data_bram_din;
    logic                     h_data_bram_ena;
    logic                     h_data_bram_wea;
    logic [H_DATA_WIDTH-1:0]  h_data_bram_dout;

    logic [H_DATA_WIDTH-1:0]  rd_data;
    logic [1:0]               rd_vld;
    logic                     busy;

    modport slave (
        input  req0_vld, req0_last, req0_we, req0_addr, req0_din,
        output req0_rdy,
        input  req1_vld, req1_last, req1_we, req1_addr, req1_din,
        output req1_rdy,
        output h_data_bram_addra, h_data_bram_din, h_data_bram_ena, h_data_bram_wea,
        input  h_data_bram_dout,
        output rd_data, rd_vld, busy
    );

    modport master (
        output req0_vld, req0_last, req0_we, req0_addr, req0_din,
        input  req0_rdy,
        output req1_vld, req1_last, req1_we, req1_addr, req1_din,
        input  req1_rdy,
        input  h_data_bram_addra, h_data_bram_din, h_data_bram_ena, h_data_bram_wea,
        output h_data_bram_dout,
        input  rd_data, rd_vld, busy
    );
endinterface

// File: rtl/h_data_port_arbiter.sv
// rtl/h_data_port_arbiter.sv - burst round-robin arbiter sharing H-data BRAM port A between two requesters
module h_data_port_arbiter #(
    parameter int H_DATA_ADDR_W = 18,
    parameter int H_DATA_WIDTH  = 19,
    parameter int MAX_BURST     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    h_data_port_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

    logic                     acc;
    logic                     beat_we;
    logic                     beat_last;
    logic [H_DATA_ADDR_W-1:0] beat_addr;
    logic [H_DATA_WIDTH-1:0]  beat_din;

    logic rd_p1_vld, rd_p1_own;
    logic rd_p2_vld, rd_p2_own;

    // Beat fields come from whichever requester currently owns the grant.
    always_comb begin
        beat_we   = bus.req0_we;
        beat_last = bus.req0_last;
        beat_addr = bus.req0_addr;
        beat_din  = bus.req0_din;
        if (state == GRANT1) begin
            beat_we   = bus.req1_we;
            beat_last = bus.req1_last;
            beat_addr = bus.req1_addr;
            beat_din  = bus.req1_din;
        end
        acc = ((state == GRANT0) && bus.req0_vld) || ((state == GRANT1) && bus.req1_vld);
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (bus.req0_vld && bus.req1_vld)
                    state_nxt = rr_ptr ? GRANT1 : GRANT0;
                else if (bus.req0_vld)
                    state_nxt = GRANT0;
                else if (bus.req1_vld)
                    state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (acc) begin
                    if (beat_last || (beat_cnt == LAST_CNT)) begin
                        state_nxt    = IDLE;
                        beat_cnt_nxt = '0;
                        rr_ptr_nxt   = (state == GRANT0);
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Address/data hold their last value between beats; only enables drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.h_data_bram_ena   <= 1'b0;
            bus.h_data_bram_wea   <= 1'b0;
            bus.h_data_bram_addra <= '0;
            bus.h_data_bram_din   <= '0;
            rd_p1_vld             <= 1'b0;
            rd_p1_own             <= 1'b0;
            rd_p2_vld             <= 1'b0;
            rd_p2_own             <= 1'b0;
        end else begin
            bus.h_data_bram_ena <= acc;
            bus.h_data_bram_wea <= acc && beat_we;
            if (acc) begin
                bus.h_data_bram_addra <= beat_addr;
                bus.h_data_bram_din   <= beat_din;
            end
            rd_p1_vld <= acc && !beat_we;
            rd_p1_own <= (state == GRANT1);
            rd_p2_vld <= rd_p1_vld;
            rd_p2_own <= rd_p1_own;
        end
    end

    assign bus.req0_rdy = (state == GRANT0);
    assign bus.req1_rdy = (state == GRANT1);
    assign bus.busy     = (state != IDLE);
    assign bus.rd_vld   = {rd_p2_vld && rd_p2_own, rd_p2_vld && !rd_p2_own};
    assign bus.rd_data  = rd_p2_vld ? bus.h_data_bram_dout : '0;
endmodule
